mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single memory access path between two requesters: the instruction-fetch side (address from `pc`) and the load/store side (ALU address plus register write data). Each requester gets a valid/ready request handshake and a response strobe. The arbiter keeps one access in flight, drives the memory's address, write-data and read/write strobes, and returns read data to the requester that owns the access. It sits between the core datapath and `Memory`; it is what allows the fetch and data ports to be served by a single-ported memory.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, cycles the memory command is held before read data is sampled; legal range 1..4
- `STARVE_MAX`, 4, maximum consecutive data grants while fetch waits (only with the guard macro)

Ports (one clock, `clk`; reset `rst` is asynchronous and active-high):
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous reset, active-high
- `if_req`  in  1  fetch request
- `if_addr`  in  ADDR_W  fetch address
- `if_ready`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  fetch data valid, one-cycle pulse
- `if_rdata`  out  DATA_W  fetched instruction
- `d_req`  in  1  data request
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_ready`  out  1  data request accepted this cycle
- `d_rvalid`  out  1  data response, one-cycle pulse (load data or store ack)
- `d_rdata`  out  DATA_W  load data; 0 for a store ack
- `mem_addr`  out  ADDR_W  to memory
- `mem_wdata`  out  DATA_W  to memory
- `mem_read`  out  1  to memory
- `mem_write`  out  1  to memory
- `mem_rdata`  in  DATA_W  from memory
- `busy`  out  1  access in flight

## Operation
- FSM states: `IDLE`, `ACCESS`, `RESP`.
- **IDLE:** if `d_req`, grant data; else if `if_req`, grant fetch; else stay. A grant raises the winner's `*_ready` combinationally in the same cycle, latches the owner, address, write data and direction, and moves to `ACCESS`.
- **ACCESS:** `mem_addr`/`mem_wdata` and exactly one of `mem_read`/`mem_write` are held for MEM_LAT cycles. In the last cycle, `mem_rdata` is captured (loads and fetches only). Then go to `RESP`.
- **RESP:** pulse the owner's `*_rvalid` with the captured data (`d_rdata`=0 for stores). RESP behaves as IDLE for arbitration: a new grant can be issued in the same cycle, going straight to `ACCESS`; otherwise go to `IDLE`.
- **Handshake rules:**
  - A requester holds `req` and its payload stable until `ready`.
  - Dropping `req` before `ready` withdraws the request with no side effect.
  - `ready` is never high in `ACCESS`.
- Only one access is in flight at a time. `*_rvalid` is never asserted for a requester that does not own the access.
- Simultaneous `if_req` and `d_req`: data wins (see Configuration).
- **Reset, including mid-access:** return to `IDLE`; the in-flight access is dropped with no `rvalid`. All outputs read 0: `*_ready`, `*_rvalid`, `*_rdata`, `mem_*`, `busy`. The starvation counter also resets to 0.
- `busy` = 1 in `ACCESS` and in `RESP`.

## Timing
- Grant in cycle T. `mem_*` driven in T+1..T+MEM_LAT. `rvalid` in T+MEM_LAT+1.
- Back-to-back throughput: one access per MEM_LAT+1 cycles. With MEM_LAT=1: grant T, memory T+1, response T+2, next grant T+2.
- `*_ready` is combinational from the FSM state and `*_req`. All other outputs are registered.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A counter counts consecutive data grants issued while `if_req` is high.
  - When the counter equals STARVE_MAX and `if_req` is high, fetch wins over `d_req`.
  - The counter clears on any fetch grant, or on a data grant with `if_req` low.
- Undefined: strict data priority, no counter logic.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the FSM state enum;
  - the owner enum (`OWN_IF`, `OWN_D`);
  - the latency-counter width constant, `$clog2(4)+1`.
- One sub-module, `mem_arb_pick`: combinational priority and starvation-guard selection. It takes the two `req` signals and the counter-saturated flag, and outputs the grant.

## Test plan
- **Idle fetch:** reset, then `if_req`=1, `if_addr`=0x40, `mem_rdata`=0xDEADBEEF.
  - Expect `if_ready` at T, `mem_read`=1 with `mem_addr`=0x40 at T+1, `if_rvalid`=1 with `if_rdata`=0xDEADBEEF at T+2.
- **Conflict:** `if_req` and `d_req` (load, 0x100) both asserted at T.
  - Expect `d_ready` at T and `if_ready` at T+2.
  - Expect `d_rvalid` at T+2 and `if_rvalid` at T+4.
- **Store:** `d_we`=1, `d_addr`=0x200, `d_wdata`=0x12345678.
  - Expect `mem_write`=1 for one cycle with matching address and data.
  - Expect `d_rvalid`=1 with `d_rdata`=0; `mem_read` stays 0.
- **MEM_LAT=3:** a single fetch.
  - Expect `mem_read` held for 3 cycles, `if_rvalid` at T+4, and `if_ready` low throughout.
- **Reset mid-access:** assert `rst` at T+1 of a load.
  - Expect all outputs 0 immediately and no `d_rvalid` after release.
  - A fresh fetch then completes normally.
- **Guard (macro on, STARVE_MAX=4):** hold `d_req` and `if_req` high continuously.
  - Expect grant order D,D,D,D,I,D,D,D,D,I.
  - With the macro off, fetch is never granted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Wide enough to count down the longest legal memory latency.
    localparam int LAT_CNT_W = $clog2(4) + 1;

endpackage

// File: rtl/mem_arb_pick.sv
// Priority select between fetch and data requests; with MEM_ARB_STARVE_GUARD_EN
// a saturated starvation counter hands priority to a waiting fetch.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req_i,
    input  logic   d_req_i,
    input  logic   starve_sat_i,
    output logic   grant_valid_o,
    output owner_t grant_owner_o
);

    logic fetch_first;

`ifdef MEM_ARB_STARVE_GUARD_EN
    assign fetch_first = starve_sat_i & if_req_i;
`else
    logic unused_sat;
    assign unused_sat  = starve_sat_i;
    assign fetch_first = 1'b0;
`endif

    always_comb begin
        grant_valid_o = if_req_i | d_req_i;
        grant_owner_o = (d_req_i & ~fetch_first) ? OWN_D : OWN_IF;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one access
// in flight. Optional fetch starvation guard: MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    state_t               state_q;
    owner_t               owner_q;
    logic                 we_q;
    logic [LAT_CNT_W-1:0] lat_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]    mem_wdata_q;
    logic                 mem_read_q;
    logic                 mem_write_q;
    logic                 if_rvalid_q;
    logic [DATA_W-1:0]    if_rdata_q;
    logic                 d_rvalid_q;
    logic [DATA_W-1:0]    d_rdata_q;
    logic                 busy_q;

    logic   can_grant;
    logic   grant_valid;
    logic   grant_en;
    logic   grant_store;
    logic   starve_sat;
    owner_t grant_owner;

    mem_arb_pick u_pick (
        .if_req_i      (if_req),
        .d_req_i       (d_req),
        .starve_sat_i  (starve_sat),
        .grant_valid_o (grant_valid),
        .grant_owner_o (grant_owner)
    );

    // RESP arbitrates like IDLE; gating with rst keeps ready at 0 during reset.
    assign can_grant   = ~rst & (state_q != ACCESS);
    assign if_ready    = can_grant & grant_valid & (grant_owner == OWN_IF);
    assign d_ready     = can_grant & grant_valid & (grant_owner == OWN_D);
    assign grant_en    = if_ready | d_ready;
    assign grant_store = d_ready & d_we;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;

    always_comb begin
        // NOTE: default assignment first so the combinational block never infers a latch.
        starve_d = starve_q;
        if (d_ready & if_req)
            starve_d = starve_q + STARVE_W'(1);
        else if (grant_en)
            starve_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end

    assign starve_sat = (starve_q == STARVE_W'(STARVE_MAX));
`else
    logic unused_starve_cfg;
    assign unused_starve_cfg = (STARVE_W == 0);
    assign starve_sat        = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            lat_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            case (state_q)
                ACCESS: begin
                    if (lat_q == '0) begin
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (owner_q == OWN_D) begin
                            d_rvalid_q <= 1'b1;
                            d_rdata_q  <= we_q ? '0 : mem_rdata;
                        end else begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= mem_rdata;
                        end
                        state_q <= RESP;
                    end else begin
                        lat_q <= lat_q - LAT_CNT_W'(1);
                    end
                end
                default: begin
                    if (grant_en) begin
                        state_q     <= ACCESS;
                        owner_q     <= grant_owner;
                        we_q        <= grant_store;
                        lat_q       <= LAT_CNT_W'(MEM_LAT - 1);
                        mem_addr_q  <= d_ready ? d_addr : if_addr;
                        mem_wdata_q <= grant_store ? d_wdata : '0;
                        mem_read_q  <= ~grant_store;
                        mem_write_q <= grant_store;
                        busy_q      <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps plus random traffic checked against
// a transaction-timing reference model; second instance exercises MEM_LAT=3.
module tb_mem_port_arbiter;

    localparam int LAT  = 1;
    localparam int SMAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
    endfunction

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_ready, if_rvalid, d_ready, d_rvalid, mem_read, mem_write, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    assign mem_rdata = mem_fn(mem_addr);

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
    );

    logic        l3_if_req, l3_d_req, l3_d_we;
    logic [31:0] l3_if_addr, l3_d_addr, l3_d_wdata;
    logic        l3_if_ready, l3_if_rvalid, l3_d_ready, l3_d_rvalid;
    logic        l3_mem_read, l3_mem_write, l3_busy;
    logic [31:0] l3_if_rdata, l3_d_rdata, l3_mem_addr, l3_mem_wdata, l3_mem_rdata;
    assign l3_mem_rdata = mem_fn(l3_mem_addr);

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(SMAX)) dut_l3 (
        .clk(clk), .rst(rst),
        .if_req(l3_if_req), .if_addr(l3_if_addr), .if_ready(l3_if_ready),
        .if_rvalid(l3_if_rvalid), .if_rdata(l3_if_rdata),
        .d_req(l3_d_req), .d_we(l3_d_we), .d_addr(l3_d_addr), .d_wdata(l3_d_wdata),
        .d_ready(l3_d_ready), .d_rvalid(l3_d_rvalid), .d_rdata(l3_d_rdata),
        .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata), .mem_read(l3_mem_read),
        .mem_write(l3_mem_write), .mem_rdata(l3_mem_rdata), .busy(l3_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: the last grant's cycle fixes the command window and response slot.
    int          cyc = 0;
    int          last_g = -100;
    int          starve = 0;
    int          gcount = 0;
    logic [31:0] gvec = '0;
    logic        g_own_d, g_we, saw_if_ready, saw_d_ready;
    logic [31:0] g_addr, g_wdata, g_data;

    task automatic model_check();
        bit in_cmd, in_resp, can, pick_d, pick_i;
        if (rst) begin
            check("rst_ctrl", {if_ready, if_rvalid, d_ready, d_rvalid, mem_read, mem_write, busy}, '0);
            check("rst_if_rdata", if_rdata, '0);
            check("rst_d_rdata", d_rdata, '0);
            check("rst_mem_addr", mem_addr, '0);
            check("rst_mem_wdata", mem_wdata, '0);
            last_g = -100; starve = 0; saw_if_ready = 1'b0; saw_d_ready = 1'b0;
            return;
        end
        in_cmd  = (cyc > last_g) && (cyc <= last_g + LAT);
        in_resp = (cyc == last_g + LAT + 1);
        check("busy", busy, in_cmd || in_resp);
        check("mem_read", mem_read, in_cmd && !g_we);
        check("mem_write", mem_write, in_cmd && g_we);
        check("mem_addr", mem_addr, in_cmd ? g_addr : 32'h0);
        check("mem_wdata", mem_wdata, (in_cmd && g_we) ? g_wdata : 32'h0);
        check("if_rvalid", if_rvalid, in_resp && !g_own_d);
        check("if_rdata", if_rdata, (in_resp && !g_own_d) ? g_data : 32'h0);
        check("d_rvalid", d_rvalid, in_resp && g_own_d);
        check("d_rdata", d_rdata, (in_resp && g_own_d) ? g_data : 32'h0);
        can    = (cyc >= last_g + LAT + 1);
        pick_d = d_req && !(GUARD && starve == SMAX && if_req);
        pick_i = if_req && !pick_d;
        check("if_ready", if_ready, can && pick_i);
        check("d_ready", d_ready, can && pick_d);
        saw_if_ready = if_ready;
        saw_d_ready  = d_ready;
        if (can && (pick_d || pick_i)) begin
            last_g  = cyc;
            g_own_d = pick_d;
            g_we    = pick_d && d_we;
            g_addr  = pick_d ? d_addr : if_addr;
            g_wdata = d_wdata;
            g_data  = g_we ? 32'h0 : mem_fn(g_addr);
            gvec    = {gvec[30:0], pick_d};
            gcount++;
            if (GUARD) starve = (pick_d && if_req) ? starve + 1 : 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        {if_req, d_req, d_we} = '0; if_addr = '0; d_addr = '0; d_wdata = '0;
        {l3_if_req, l3_d_req, l3_d_we} = '0; l3_if_addr = '0; l3_d_addr = '0; l3_d_wdata = '0;
        step(); adv();
        rst = 1'b0;
        step(); adv();

        // Idle fetch
        if_req = 1'b1; if_addr = 32'h40;
        step(); check("fetch_ready", if_ready, 1'b1); adv();
        if_req = 1'b0;
        step(); check("fetch_mem_read", mem_read, 1'b1); check("fetch_mem_addr", mem_addr, 32'h40); adv();
        step(); check("fetch_rvalid", if_rvalid, 1'b1); check("fetch_rdata", if_rdata, 32'hDEAD_BEEF); adv();

        // Conflict: data wins, fetch follows in the response cycle
        if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        step(); check("conf_d_ready", d_ready, 1'b1); check("conf_if_wait", if_ready, 1'b0); adv();
        d_req = 1'b0;
        step(); check("conf_if_wait_acc", if_ready, 1'b0); adv();
        step(); check("conf_d_rvalid", d_rvalid, 1'b1); check("conf_d_rdata", d_rdata, mem_fn(32'h100));
        check("conf_if_ready", if_ready, 1'b1); adv();
        if_req = 1'b0;
        step(); adv();
        step(); check("conf_if_rvalid", if_rvalid, 1'b1); check("conf_if_rdata", if_rdata, mem_fn(32'h80)); adv();

        // Store
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234_5678;
        step(); check("st_ready", d_ready, 1'b1); adv();
        d_req = 1'b0; d_we = 1'b0;
        step(); check("st_mem_write", mem_write, 1'b1); check("st_mem_read", mem_read, 1'b0);
        check("st_mem_addr", mem_addr, 32'h200); check("st_mem_wdata", mem_wdata, 32'h1234_5678); adv();
        step(); check("st_rvalid", d_rvalid, 1'b1); check("st_rdata", d_rdata, 32'h0);
        check("st_write_done", mem_write, 1'b0); adv();

        // MEM_LAT=3 instance: single fetch, request kept high through the access
        l3_if_req = 1'b1; l3_if_addr = 32'h500;
        step(); check("l3_ready", l3_if_ready, 1'b1); adv();
        for (int k = 1; k <= 3; k++) begin
            step();
            check("l3_mem_read", l3_mem_read, 1'b1);
            check("l3_mem_addr", l3_mem_addr, 32'h500);
            check("l3_ready_low", l3_if_ready, 1'b0);
            check("l3_no_rvalid", l3_if_rvalid, 1'b0);
            adv();
        end
        l3_if_req = 1'b0;
        step(); check("l3_rvalid", l3_if_rvalid, 1'b1); check("l3_rdata", l3_if_rdata, mem_fn(32'h500));
        check("l3_read_done", l3_mem_read, 1'b0); adv();
        step(); check("l3_idle", l3_busy, 1'b0); adv();

        // Reset in the middle of a load
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        step(); check("rm_ready", d_ready, 1'b1); adv();
        d_req = 1'b0; rst = 1'b1;
        #1;
        check("rm_ctrl", {if_ready, if_rvalid, d_ready, d_rvalid, mem_read, mem_write, busy}, '0);
        check("rm_mem_addr", mem_addr, '0);
        step(); adv();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(); check("rm_no_rvalid", d_rvalid, 1'b0); adv();
        end
        if_req = 1'b1; if_addr = 32'h44;
        step(); check("rm_fetch_ready", if_ready, 1'b1); adv();
        if_req = 1'b0;
        step(); adv();
        step(); check("rm_fetch_rvalid", if_rvalid, 1'b1); check("rm_fetch_rdata", if_rdata, mem_fn(32'h44)); adv();

        // Continuous contention: grant order depends on the starvation guard
        rst = 1'b1; step(); adv(); rst = 1'b0;
        gvec = '0; gcount = 0;
        if_req = 1'b1; if_addr = 32'h700; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
        for (int i = 0; i < 100 && gcount < 10; i++) begin
            step(); adv();
            if (saw_d_ready)  d_addr  = d_addr + 32'h4;
            if (saw_if_ready) if_addr = if_addr + 32'h4;
        end
        check("guard_count", gcount, 10);
        check("guard_order", {22'h0, gvec[9:0]}, GUARD ? 32'h3DE : 32'h3FF);
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) begin step(); adv(); end

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            step(); adv();
            if (if_req && (saw_if_ready || $urandom_range(0, 9) == 0)) if_req = 1'b0;
            else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom & 32'h0000_FFFC;
            end
            if (d_req && (saw_d_ready || $urandom_range(0, 9) == 0)) d_req = 1'b0;
            else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = $urandom_range(0, 1) == 1;
                d_addr = $urandom & 32'h0000_FFFC; d_wdata = $urandom;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (4) begin step(); adv(); end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
